// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bundle between the pipeline (core + debug/loader ports) and dmem_lane_ctrl.
interface dmem_lane_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  REQ;
    logic                  WE;
    logic [2:0]            FUNCT3;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [31:0]           WDATA;
    logic                  BUSY;
    logic [31:0]           RDATA;
    logic                  RVALID;
    logic                  ERR;
    logic                  DBG_REQ;
    logic                  DBG_WE;
    logic [ADDR_WIDTH-3:0] DBG_ADDR;
    logic [31:0]           DBG_WDATA;
    logic                  DBG_GNT;
    logic [31:0]           DBG_RDATA;
    logic                  DBG_RVALID;

    modport master (
        output REQ, WE, FUNCT3, ADDR, WDATA, DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
        input  BUSY, RDATA, RVALID, ERR, DBG_GNT, DBG_RDATA, DBG_RVALID
    );

    modport slave (
        input  REQ, WE, FUNCT3, ADDR, WDATA, DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA,
        output BUSY, RDATA, RVALID, ERR, DBG_GNT, DBG_RDATA, DBG_RVALID
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Four byte-lane BRAM data-memory controller: RISC-V load/store decode incl. misaligned
// accesses, plus core/debug arbitration with a starvation guard.
module dmem_lane_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    dmem_lane_ctrl_if.slave             bus,
    output logic [4*(ADDR_WIDTH-2)-1:0] LANE_W_ADDR,
    output logic [4*(ADDR_WIDTH-2)-1:0] LANE_R_ADDR,
    output logic [3:0]                  LANE_WE,
    output logic [3:0]                  LANE_RE,
    output logic [31:0]                 LANE_DIN,
    input  logic [31:0]                 LANE_DOUT
);
    localparam int WA  = ADDR_WIDTH - 2;
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int CW  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]       starve_cnt;
    logic                dbg_win;
    logic                core_gnt;
    logic [1:0]          off;
    logic [WA-1:0]       word;
    logic [2:0]          size;
    logic                legal_op;
    logic                in_range;
    logic                access_ok;
    logic [ADDR_WIDTH:0] last_byte;
    logic [1:0]          rel [4];
    logic [3:0]          touched;
    logic [WA-1:0]       lane_addr [4];
    logic                rvalid_q;
    logic                dbg_rvalid_q;
    logic                err_q;
    logic [1:0]          off_q;
    logic [2:0]          f3_q;
    logic                rvalid;
    logic [31:0]         gathered;
    logic [31:0]         load_word;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        dbg_win  = RSTN && bus.DBG_REQ && (!bus.REQ || starve_cnt == CW'(STARVE_LIMIT));
        core_gnt = RSTN && bus.REQ && !dbg_win;
    end

    assign bus.BUSY    = RSTN && bus.REQ && !core_gnt;
    assign bus.DBG_GNT = dbg_win;

    // Counts consecutive cycles the debug port asked and lost; saturates at the limit by construction.
    always_ff @(posedge CLK) begin
        if (!RSTN || dbg_win || !bus.DBG_REQ) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_comb begin
        off  = bus.ADDR[1:0];
        word = bus.ADDR[ADDR_WIDTH-1:2];
        case (bus.FUNCT3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        case (bus.FUNCT3)
            3'b000, 3'b001, 3'b010: legal_op = 1'b1;
            3'b100, 3'b101:         legal_op = !bus.WE;
            default:                legal_op = 1'b0;
        endcase
        last_byte = {1'b0, bus.ADDR} + AW1'(size - 3'd1);
        in_range  = !last_byte[ADDR_WIDTH];
        access_ok = legal_op && in_range;
        // Lanes below the offset belong to the following word, so a crossing access completes in one cycle.
        for (int j = 0; j < 4; j++) begin
            rel[j]       = 2'(j) - off;
            touched[j]   = {1'b0, rel[j]} < size;
            lane_addr[j] = (2'(j) < off) ? word + WA'(1) : word;
        end
    end

    always_comb begin
        LANE_WE     = '0;
        LANE_RE     = '0;
        LANE_W_ADDR = '0;
        LANE_R_ADDR = '0;
        LANE_DIN    = '0;
        if (dbg_win) begin
            for (int j = 0; j < 4; j++) begin
                LANE_W_ADDR[j*WA +: WA] = bus.DBG_ADDR;
                LANE_R_ADDR[j*WA +: WA] = bus.DBG_ADDR;
            end
            LANE_DIN = bus.DBG_WDATA;
            if (bus.DBG_WE) begin
                LANE_WE = 4'hF;
            end else begin
                LANE_RE = 4'hF;
            end
        end else if (core_gnt) begin
            for (int j = 0; j < 4; j++) begin
                LANE_W_ADDR[j*WA +: WA] = lane_addr[j];
                LANE_R_ADDR[j*WA +: WA] = lane_addr[j];
                LANE_DIN[j*8 +: 8]      = pick_byte(bus.WDATA, rel[j]);
            end
            if (access_ok) begin
                if (bus.WE) begin
                    LANE_WE = touched;
                end else begin
                    LANE_RE = touched;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rvalid_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            off_q        <= '0;
            f3_q         <= '0;
        end else begin
            rvalid_q     <= core_gnt && access_ok && !bus.WE;
            dbg_rvalid_q <= dbg_win && !bus.DBG_WE;
            err_q        <= core_gnt && !access_ok;
            if (core_gnt && access_ok && !bus.WE) begin
                off_q <= off;
                f3_q  <= bus.FUNCT3;
            end
        end
    end

    // A load returning while reset is held is dropped immediately rather than one cycle later.
    assign rvalid = rvalid_q && RSTN;

    always_comb begin
        gathered = '0;
        for (int k = 0; k < 4; k++) begin
            gathered[k*8 +: 8] = pick_byte(LANE_DOUT, 2'(k) + off_q);
        end
        case (f3_q[1:0])
            2'b00:   load_word = {{24{!f3_q[2] && gathered[7]}}, gathered[7:0]};
            2'b01:   load_word = {{16{!f3_q[2] && gathered[15]}}, gathered[15:0]};
            default: load_word = gathered;
        endcase
    end

    assign bus.RVALID     = rvalid;
    assign bus.RDATA      = rvalid ? load_word : '0;
    assign bus.ERR        = err_q;
    assign bus.DBG_RVALID = dbg_rvalid_q;
    assign bus.DBG_RDATA  = dbg_rvalid_q ? LANE_DOUT : '0;
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Scoreboard bench for dmem_lane_ctrl: byte-array reference memory, queued expected responses,
// and a negedge monitor comparing lane activity, arbitration and returned data.
module tb_dmem_lane_ctrl;
    localparam int AW    = 8;
    localparam int WA    = AW - 2;
    localparam int LIMIT = 3;

    typedef struct {
        int          due;
        bit          is_err;
        logic [31:0] data;
    } resp_t;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [4*WA-1:0] LANE_W_ADDR;
    logic [4*WA-1:0] LANE_R_ADDR;
    logic [3:0]      LANE_WE;
    logic [3:0]      LANE_RE;
    logic [31:0]     LANE_DIN;
    logic [31:0]     LANE_DOUT = '0;

    logic [7:0]      bram [4][64] = '{default: '0};
    logic [7:0]      ref_mem [256] = '{default: '0};

    int              cyc = 0;
    int              lost = 0;
    int              errors = 0;
    int              checks = 0;
    resp_t           core_q[$];
    resp_t           dbg_q[$];
    logic            exp_busy = 1'b0;
    logic            exp_gnt = 1'b0;
    logic [3:0]      exp_we = '0;
    logic [3:0]      exp_re = '0;
    logic [WA-1:0]   exp_addr [4] = '{default: '0};
    logic [7:0]      exp_din [4] = '{default: '0};

    dmem_lane_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_lane_ctrl #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .bus        (bus),
        .LANE_W_ADDR(LANE_W_ADDR),
        .LANE_R_ADDR(LANE_R_ADDR),
        .LANE_WE    (LANE_WE),
        .LANE_RE    (LANE_RE),
        .LANE_DIN   (LANE_DIN),
        .LANE_DOUT  (LANE_DOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Byte-lane BRAMs with one cycle of registered read latency.
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (LANE_WE[i]) bram[i][LANE_W_ADDR[i*WA +: WA]] <= LANE_DIN[i*8 +: 8];
            if (LANE_RE[i]) LANE_DOUT[i*8 +: 8] <= bram[i][LANE_R_ADDR[i*WA +: WA]];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model for that cycle.
    task automatic apply_stimulus(
        input  logic          rstn,
        input  logic          req,
        input  logic          we,
        input  logic [2:0]    f3,
        input  logic [AW-1:0] addr,
        input  logic [31:0]   wdata,
        input  logic          dreq,
        input  logic          dwe,
        input  logic [WA-1:0] daddr,
        input  logic [31:0]   dwdata,
        output bit            core_acc,
        output bit            dbg_acc
    );
        bit          core_wins;
        bit          dbg_wins;
        bit          ok;
        int          size;
        int          a;
        logic [31:0] v;
        @(posedge CLK);
        #1;
        RSTN          = rstn;
        bus.REQ       = req;
        bus.WE        = we;
        bus.FUNCT3    = f3;
        bus.ADDR      = addr;
        bus.WDATA     = wdata;
        bus.DBG_REQ   = dreq;
        bus.DBG_WE    = dwe;
        bus.DBG_ADDR  = daddr;
        bus.DBG_WDATA = dwdata;
        exp_we   = '0;
        exp_re   = '0;
        exp_busy = 1'b0;
        exp_gnt  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_addr[i] = '0;
            exp_din[i]  = '0;
        end
        core_acc = 1'b0;
        dbg_acc  = 1'b0;
        if (!rstn) begin
            lost = 0;
            if (core_q.size() != 0 && core_q[0].due == cyc && !core_q[0].is_err) core_q.delete(0);
            return;
        end
        core_wins = req && !(dreq && lost == LIMIT);
        dbg_wins  = dreq && !core_wins;
        lost      = (dreq && !dbg_wins) ? lost + 1 : 0;
        exp_busy  = req && !core_wins;
        exp_gnt   = dbg_wins;
        if (core_wins) begin
            core_acc = 1'b1;
            size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            ok = (we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
                 && (int'(addr) + size - 1 <= (1 << AW) - 1);
            if (!ok) begin
                core_q.push_back('{cyc + 1, 1'b1, 32'h0});
            end else begin
                v = '0;
                for (int k = 0; k < size; k++) begin
                    a = int'(addr) + k;
                    exp_addr[a % 4] = WA'(a / 4);
                    if (we) begin
                        exp_we[a % 4]  = 1'b1;
                        exp_din[a % 4] = wdata[8*k +: 8];
                        ref_mem[a]     = wdata[8*k +: 8];
                    end else begin
                        exp_re[a % 4] = 1'b1;
                        v[8*k +: 8]   = ref_mem[a];
                    end
                end
                if (!we) begin
                    if (!f3[2] && size < 4 && v[8*size-1]) begin
                        for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
                    end
                    core_q.push_back('{cyc + 1, 1'b0, v});
                end
            end
        end
        if (dbg_wins) begin
            dbg_acc = 1'b1;
            v = '0;
            for (int i = 0; i < 4; i++) begin
                a = int'(daddr) * 4 + i;
                exp_addr[i] = daddr;
                if (dwe) begin
                    exp_we[i]  = 1'b1;
                    exp_din[i] = dwdata[8*i +: 8];
                    ref_mem[a] = dwdata[8*i +: 8];
                end else begin
                    exp_re[i]  = 1'b1;
                    v[8*i +: 8] = ref_mem[a];
                end
            end
            if (!dwe) dbg_q.push_back('{cyc + 1, 1'b0, v});
        end
    endtask

    task automatic core_op(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                           input logic [31:0] wdata);
        bit ca;
        bit da;
        apply_stimulus(1'b1, 1'b1, we, f3, addr, wdata, 1'b0, 1'b0, '0, '0, ca, da);
    endtask

    // Monitor: compares everything the DUT presents against the expectations of the current cycle.
    initial begin
        resp_t e;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            check_output("busy", 32'(bus.BUSY), 32'(exp_busy));
            check_output("dbg_gnt", 32'(bus.DBG_GNT), 32'(exp_gnt));
            check_output("lane_we", 32'(LANE_WE), 32'(exp_we));
            check_output("lane_re", 32'(LANE_RE), 32'(exp_re));
            for (int i = 0; i < 4; i++) begin
                if (exp_we[i]) begin
                    check_output("lane_w_addr", 32'(LANE_W_ADDR[i*WA +: WA]), 32'(exp_addr[i]));
                    check_output("lane_din", 32'(LANE_DIN[i*8 +: 8]), 32'(exp_din[i]));
                end
                if (exp_re[i]) check_output("lane_r_addr", 32'(LANE_R_ADDR[i*WA +: WA]), 32'(exp_addr[i]));
            end
            if (core_q.size() != 0 && core_q[0].due == cyc) begin
                e = core_q.pop_front();
                check_output("err", 32'(bus.ERR), 32'(e.is_err));
                check_output("rvalid", 32'(bus.RVALID), 32'(!e.is_err));
                if (!e.is_err) check_output("rdata", bus.RDATA, e.data);
            end else begin
                check_output("err_idle", 32'(bus.ERR), 32'h0);
                check_output("rvalid_idle", 32'(bus.RVALID), 32'h0);
                check_output("rdata_idle", bus.RDATA, 32'h0);
            end
            if (dbg_q.size() != 0 && dbg_q[0].due == cyc) begin
                e = dbg_q.pop_front();
                check_output("dbg_rvalid", 32'(bus.DBG_RVALID), 32'h1);
                check_output("dbg_rdata", bus.DBG_RDATA, e.data);
            end else begin
                check_output("dbg_rvalid_idle", 32'(bus.DBG_RVALID), 32'h0);
                check_output("dbg_rdata_idle", bus.DBG_RDATA, 32'h0);
            end
        end
    end

    initial begin
        bit            ca;
        bit            da;
        bit            cp;
        bit            dp;
        logic          cwe;
        logic [2:0]    cf3;
        logic [AW-1:0] caddr;
        logic [31:0]   cwd;
        logic          dwe;
        logic [WA-1:0] dad;
        logic [31:0]   dwd;
        RSTN = 1'b0;
        bus.REQ = 1'b0; bus.WE = 1'b0; bus.FUNCT3 = '0; bus.ADDR = '0; bus.WDATA = '0;
        bus.DBG_REQ = 1'b0; bus.DBG_WE = 1'b0; bus.DBG_ADDR = '0; bus.DBG_WDATA = '0;
        cp = 1'b0; dp = 1'b0; cwe = 1'b0; cf3 = '0; caddr = '0; cwd = '0; dwe = 1'b0; dad = '0; dwd = '0;
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, ca, da);

        core_op(1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
        core_op(1'b0, 3'b010, 8'h10, '0);
        core_op(1'b0, 3'b000, 8'h13, '0);
        core_op(1'b0, 3'b100, 8'h13, '0);
        core_op(1'b0, 3'b001, 8'h12, '0);
        core_op(1'b0, 3'b101, 8'h10, '0);
        core_op(1'b1, 3'b010, 8'h1E, 32'h11223344);
        core_op(1'b0, 3'b010, 8'h1E, '0);
        core_op(1'b0, 3'b010, 8'hFE, '0);
        core_op(1'b0, 3'b011, 8'h20, '0);
        core_op(1'b1, 3'b100, 8'h20, 32'h55AA55AA);
        core_op(1'b1, 3'b001, 8'hFF, 32'h0000CAFE);
        core_op(1'b0, 3'b001, 8'hFE, '0);
        core_op(1'b1, 3'b001, 8'h07, 32'h0000A55A);
        core_op(1'b0, 3'b101, 8'h07, '0);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 3'b010, 8'h10, '0, 1'b1, 1'b0, 6'd4, '0, ca, da);
        end

        core_op(1'b0, 3'b010, 8'h1E, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 3'b010, 8'h10, '0, 1'b1, 1'b0, 6'd4, '0, ca, da);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 3'b010, 8'h10, '0, 1'b1, 1'b0, 6'd4, '0, ca, da);
        end

        for (int n = 0; n < 600; n++) begin
            if (!cp && $urandom_range(0, 9) < 7) begin
                cp    = 1'b1;
                cwe   = 1'($urandom_range(0, 1));
                cf3   = 3'($urandom_range(0, 7));
                caddr = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom);
                cwd   = $urandom;
            end
            if (!dp && $urandom_range(0, 9) < 3) begin
                dp  = 1'b1;
                dwe = 1'($urandom_range(0, 1));
                dad = WA'($urandom_range(0, 15));
                dwd = $urandom;
            end
            apply_stimulus(1'b1, cp, cwe, cf3, caddr, cwd, dp, dwe, dad, dwd, ca, da);
            if (ca) cp = 1'b0;
            if (da) dp = 1'b0;
        end

        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, ca, da);
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
- Data-memory controller for the four byte-wide BRAM lanes that form the core's 32-bit data memory. Lane i holds byte i of each word, so byte address = 4*word + i.
- Translates RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into per-lane addresses, enables and data, including misaligned accesses.
- Shares the lanes between the pipeline's MEM stage (core port) and a word-only debug/loader port, using priority arbitration with a starvation guard.

Parameters:
- ADDR_WIDTH, 8, byte-address width; lane word-address width is ADDR_WIDTH-2.
- STARVE_LIMIT, 3, consecutive lost arbitration cycles after which the debug port wins.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  synchronous active-low reset.
- REQ  in  1  core request valid.
- WE  in  1  core store (1) / load (0).
- FUNCT3  in  3  RISC-V size/sign field.
- ADDR  in  ADDR_WIDTH  core byte address.
- WDATA  in  32  core store data, LSB-justified.
- BUSY  out  1  core request not accepted this cycle; core holds its request.
- RDATA  out  32  core load data, extended per FUNCT3.
- RVALID  out  1  core load data valid.
- ERR  out  1  core access rejected.
- DBG_REQ  in  1  debug request.
- DBG_WE  in  1  debug store/load.
- DBG_ADDR  in  ADDR_WIDTH-2  debug word address.
- DBG_WDATA  in  32  debug store word.
- DBG_GNT  out  1  debug request accepted this cycle.
- DBG_RDATA  out  32  debug load word.
- DBG_RVALID  out  1  debug load data valid.
- LANE_W_ADDR  out  4*(ADDR_WIDTH-2)  per-lane write address; lane i at bits [i*(ADDR_WIDTH-2) +: ADDR_WIDTH-2].
- LANE_R_ADDR  out  4*(ADDR_WIDTH-2)  per-lane read address, same packing.
- LANE_WE  out  4  per-lane write enable.
- LANE_RE  out  4  per-lane read enable.
- LANE_DIN  out  32  lane i gets byte [8i+7:8i].
- LANE_DOUT  in  32  lane read data; 1-cycle registered latency.

Behaviour:
- Reset (RSTN=0 at a clock edge):
  - Registered outputs clear: RVALID=0, DBG_RVALID=0, ERR=0.
  - Starvation counter clears to 0; latched offset/FUNCT3 registers clear.
  - RDATA and DBG_RDATA read 0 whenever their valid is 0.
  - While RSTN=0, all lane enables are 0, BUSY=0 and DBG_GNT=0.
- Arbitration (combinational, same cycle):
  - Core wins when REQ=1, unless DBG_REQ=1 and the counter equals STARVE_LIMIT; then the debug port wins and BUSY=1.
  - Counter increments each cycle DBG_REQ=1 and the debug port loses.
  - Counter clears on DBG_GNT or when DBG_REQ=0.
  - DBG_GNT=1 whenever the debug port is the winner.
  - BUSY=REQ && !core_granted. BUSY never asserts for any other reason.
- Core decode:
  - off = ADDR[1:0]; word = ADDR[ADDR_WIDTH-1:2]; size = 1, 2 or 4 bytes from FUNCT3[1:0].
  - Lane j is touched when ((j-off) mod 4) < size.
  - Lane j address = word+1 if j < off, else word. This makes misaligned accesses crossing a word boundary complete in one access.
  - Store byte k of WDATA goes to lane (off+k) mod 4.
- Legality:
  - Loads accept FUNCT3 000, 001, 010, 100, 101. Stores accept 000, 001, 010.
  - An access is out of range when ADDR+size-1 exceeds 2^ADDR_WIDTH-1.
  - An illegal or out-of-range access that is granted drives no lane enables. ERR=1 on the next cycle for one cycle; RVALID stays 0.
- Debug: all four lanes are touched, all at DBG_ADDR. Lane i carries DBG_WDATA byte i.
- Load latency: accepted at edge N; RVALID or DBG_RVALID=1 during cycle N+1 only.
- Core RDATA at N+1:
  - Assembled combinationally from LANE_DOUT using registered off, size and sign.
  - Byte k = lane (off+k) mod 4.
  - Result is sign- or zero-extended to 32 bits.
- Throughput: back-to-back accepted requests are supported, one per cycle. A new read may issue in the cycle its predecessor's data returns.
- Stores: lane writes occur at the accepting edge; nothing is reported on RVALID or ERR.
- Read-after-write to the same address in consecutive cycles returns the new data, through BRAM ordering (write edge precedes read edge).
- Reset asserted mid-operation: a pending RVALID from the previous cycle is dropped (forced 0).

Test Plan:
- Aligned LW: core store SW 0x00000010 := 0xDEADBEEF, then LW 0x10 → RVALID one cycle after accept, RDATA=0xDEADBEEF, BUSY=0 throughout.
- Sub-word loads: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- Misaligned store/load: SW 0x11223344 at 0x1E → lanes 2,3 written at word 7 and lanes 0,1 at word 8, in one cycle. Then LW 0x1E → 0x11223344.
- Errors: LW 0xFE with ADDR_WIDTH=8 (out of range), and FUNCT3=011 → no LANE_WE/LANE_RE, ERR=1 for one cycle, RVALID=0.
- Arbitration: REQ and DBG_REQ held high continuously → DBG_GNT on the 4th cycle (STARVE_LIMIT=3) with BUSY=1 that cycle. Debug read of word 4 returns 0xDEADBEEF on DBG_RDATA with DBG_RVALID one cycle later. Pattern then repeats.
- Reset: RSTN=0 in the cycle after an accepted LW → RVALID=0 next cycle, counter cleared, no lane enables while RSTN=0.
